mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the pipelined 64-bit datapath's load/store interface.
//  Accepts one request per cycle (valid/ready), performs byte/word/dword writes or
//  dword reads on an internal array, returns in-order responses after LATENCY cycles.
//  Response backpressure absorbed by an internal response FIFO; registered debug read port.
// PARAMETERS
//  N        64  data width (bits); fixed 64, byte lanes = N/8
//  AW       10  dword index width; array holds 2**AW dwords
//  LATENCY  2   request-accept to response-valid cycles, >=1
//  DEPTH    4   max outstanding requests (pipeline + FIFO), >=LATENCY, power of 2
// PORTS
//  clk        in   1    clock, all logic on rising edge
//  reset      in   1    synchronous, active-high
//  req_valid  in   1    request present
//  req_ready  out  1    responder can accept
//  req_write  in   2    00 read, 01 byte, 10 word(32), 11 dword write
//  req_addr   in   N    byte address
//  req_wdata  in   N    write data, low-justified
//  rsp_valid  out  1    response present
//  rsp_ready  in   1    consumer accepts response
//  rsp_rdata  out  N    read dword (0 for write responses)
//  rsp_write  out  1    1 = response belongs to a write
//  rsp_err    out  1    misaligned-access flag (see CONFIGURATION)
//  dbg_addr   in   AW   debug dword index
//  dbg_data   out  N    array[dbg_addr], registered
// BEHAVIOUR
//  - Accept = req_valid & req_ready. req_ready = (outstanding < DEPTH); combinational from count only.
//  - Index = req_addr[AW+2:3]; bits above AW+2 ignored (aliasing, no error).
//  - Byte: wdata[7:0] -> lane addr[2:0]. Word: wdata[31:0] -> half addr[2]. Dword: all 64 bits.
//  - Write committed at accept edge; read samples array at accept edge, so a read accepted
//    in cycle t+1 sees a write accepted in t. Same-cycle debug read returns pre-write data.
//  - Every accepted request yields exactly one response; order preserved.
//  - Response pipe: LATENCY-stage shift reg {valid,write,err,rdata}; stage LATENCY pushes
//    into FIFO (DEPTH entries). rsp_valid = FIFO non-empty; rsp_* = FIFO head.
//    FIFO bypass not allowed: min request->rsp_valid latency is exactly LATENCY cycles.
//  - outstanding: +1 on accept, -1 on rsp_valid&rsp_ready, unchanged if both same cycle.
//    Guarantees FIFO never overflows; push when full is a design error (assert in sim).
//  - FIFO full & rsp_ready=1: pop and push same cycle allowed.
//  - Reset: req_ready=1 after reset cycle, rsp_valid=0, rsp_rdata=0, rsp_write=0,
//    rsp_err=0, dbg_data=0, outstanding=0, pipe/FIFO pointers cleared. Array contents
//    NOT reset. Reset mid-operation drops all in-flight responses; writes already accepted
//    remain committed.
//  - req_* ignored when req_ready=0 (no write, no response).
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: word access with addr[1:0]!=0 or dword with addr[2:0]!=0
//   sets rsp_err=1 on its response; misaligned writes suppressed (array unchanged), reads
//   return 0. Undefined: rsp_err tied 0; address low bits below access size ignored
//   (word uses addr[2] only, dword ignores addr[2:0]).
// TESTING (LATENCY=2, DEPTH=4, AW=10)
//  1. dword write 64'h0123456789ABCDEF @0x10, read @0x10 next cycle -> rsp_valid 2 cycles
//     after read accept, rsp_rdata=64'h0123456789ABCDEF, rsp_write=0; write rsp has rdata 0.
//  2. byte write 8'hAA @0x13 then word write 32'hDEADBEEF @0x14, read @0x10
//     -> 64'hDEADBEEFAAABCDEF.
//  3. rsp_ready=0, 5 back-to-back reads -> 4 accepted, req_ready=0 from 5th cycle; raise
//     rsp_ready -> 4 responses in issue order, req_ready returns 1 cycle after first pop.
//  4. 3 reads in flight, reset for 1 cycle -> rsp_valid=0, no stale responses ever
//     emitted; earlier writes still readable.
//  5. read @0x10 + (1<<13) -> same data as @0x10 (alias); dbg_addr=2 -> dbg_data matches
//     one cycle later.
//  6. MEM_MISALIGN_TRAP_EN: dword write @0x11 -> rsp_err=1, @0x10 unchanged; undefined:
//     same write lands @0x10, rsp_err=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the 64-bit load/store datapath.
// Takes one request per cycle over valid/ready and performs byte, word or dword
// writes, or dword reads, on an internal array. Every accepted request produces
// exactly one response, in order, LATENCY cycles after it is accepted. A response
// FIFO absorbs consumer backpressure. A registered debug port reads the array.
//
// Optional build macro MEM_MISALIGN_TRAP_EN:
//   defined   - a misaligned word/dword access sets rsp_err on its response.
//               A misaligned write leaves the array unchanged, and a misaligned
//               read returns 0.
//   undefined - rsp_err is tied to 0, and address bits below the access size are
//               ignored.
module mem_responder #(
  parameter int N       = 64,
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_write,
  input  logic [N-1:0]  req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_rdata,
  output logic          rsp_write,
  output logic          rsp_err,
  input  logic [AW-1:0] dbg_addr,
  output logic [N-1:0]  dbg_data
);

  // Counter must hold the value DEPTH itself; pointers need at least one bit.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Pipe entry layout: {valid, write, err, rdata}.
  localparam int EW = N + 3;
  // FIFO entry layout: {write, err, rdata}.
  localparam int FW = N + 2;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_BYTE  = 2'b01;
  localparam logic [1:0] OP_WORD  = 2'b10;
  localparam logic [1:0] OP_DWORD = 2'b11;

  logic [N-1:0]  mem [2**AW];

  logic [CW-1:0] outstanding;
  logic          accept;
  logic          pop;
  logic          push;
  logic [AW-1:0] idx;
  logic [2:0]    lane;
  logic [5:0]    shamt;
  logic          is_write;
  logic          misalign;
  logic [N-1:0]  wr_mask;
  logic [N-1:0]  wr_val;
  logic [N-1:0]  rd_val;
  logic [EW-1:0] in_ent;
  logic [EW-1:0] push_ent;

  logic [FW-1:0] fifo [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [FW-1:0] head;

  // Upper address bits alias onto the array. They are deliberately unused.
  logic          unused_addr_hi;
  assign unused_addr_hi = ^req_addr[N-1:AW+3];

  // Ready depends only on the occupancy count, so it cannot form a loop with req_valid.
  assign req_ready = (outstanding < CW'(DEPTH));
  // Nothing is accepted while reset is held. This keeps the array untouched by stray requests.
  assign accept    = req_valid & req_ready & ~reset;
  assign pop       = rsp_valid & rsp_ready;

  assign idx      = req_addr[AW+2:3];
  assign lane     = req_addr[2:0];
  assign is_write = (req_write != OP_READ);

`ifdef MEM_MISALIGN_TRAP_EN
  // Decide whether the access is misaligned for its size. A read is a dword access.
  always_comb begin
    misalign = 1'b0;
    case (req_write)
      OP_WORD:  misalign = (req_addr[1:0] != 2'b00);
      OP_DWORD: misalign = (req_addr[2:0] != 3'b000);
      OP_READ:  misalign = (req_addr[2:0] != 3'b000);
      default:  misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Build the lane mask and the shifted write data for the access size.
  always_comb begin
    wr_mask = '0;
    wr_val  = '0;
    shamt   = 6'd0;
    case (req_write)
      OP_BYTE: begin
        shamt   = {lane, 3'b000};
        wr_mask = N'(8'hFF) << shamt;
        wr_val  = N'(req_wdata[7:0]) << shamt;
      end
      OP_WORD: begin
        shamt   = {req_addr[2], 5'b00000};
        wr_mask = N'(32'hFFFF_FFFF) << shamt;
        wr_val  = N'(req_wdata[31:0]) << shamt;
      end
      OP_DWORD: begin
        wr_mask = '1;
        wr_val  = req_wdata;
      end
      default: begin
        wr_mask = '0;
        wr_val  = '0;
      end
    endcase
  end

  // Reads sample the array before this edge's update. A read accepted next cycle sees this write.
  always_comb begin
    rd_val = '0;
    if (!is_write && !misalign) begin
      rd_val = mem[idx];
    end
  end

  assign in_ent = {accept, is_write, misalign, rd_val};

  // Commit an accepted, non-trapped write into the array at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && is_write && !misalign) begin
      mem[idx] <= (mem[idx] & ~wr_mask) | (wr_val & wr_mask);
    end
  end

  // Registered debug read. It returns the contents from before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
    end
  end

  // The response pipe has LATENCY-1 registers. The FIFO write is the final stage.
  // A response therefore becomes visible exactly LATENCY cycles after accept.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign push_ent = in_ent;
    end else begin : g_pipe
      logic [EW-1:0] pq [LATENCY-1];

      // Shift response entries toward the FIFO. Reset drops whatever is in flight.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            pq[i] <= '0;
          end
        end else begin
          pq[0] <= in_ent;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pq[i] <= pq[i-1];
          end
        end
      end

      assign push_ent = pq[LATENCY-2];
    end
  endgenerate

  assign push = push_ent[EW-1];

  // FIFO storage. It has no reset, because empty-slot contents are masked at the outputs.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo[wr_ptr] <= push_ent[FW-1:0];
    end
  end

  // FIFO pointers and fill count. A pop and a push may happen in the same cycle even when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // Track requests that are accepted but whose responses have not yet been consumed.
  // This covers both the pipe and the FIFO, so the FIFO can never overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(pop);
    end
  end

  // Flag a push into a full FIFO that is not draining in the same cycle. This means the outstanding count is broken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (fifo_cnt == CW'(DEPTH)) && !pop));
    end
  end

  assign head      = fifo[rd_ptr];
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_rdata = rsp_valid ? head[N-1:0] : '0;
  assign rsp_write = rsp_valid & head[N+1];

`ifdef MEM_MISALIGN_TRAP_EN
  assign rsp_err = rsp_valid & head[N];
`else
  logic unused_err_bit;
  assign unused_err_bit = head[N];
  assign rsp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: testbench for mem_responder.
// It uses directed table vectors, hand-written corner sequences and a randomized
// run. All three are compared against a request-level reference model.
module tb_mem_responder;
  localparam int N     = 64;
  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_write;
  logic [N-1:0]  req_addr;
  logic [N-1:0]  req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_rdata;
  logic          rsp_write;
  logic          rsp_err;
  logic [AW-1:0] dbg_addr;
  logic [N-1:0]  dbg_data;

  always #5 clk = ~clk;

  mem_responder #(.N(N), .AW(AW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write), .rsp_err(rsp_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference model: one expected response per accepted request, in a queue.
  // Each response carries the cycle in which it should first appear.
  typedef struct {
    logic [63:0] rdata;
    logic        write;
    logic        err;
    int          vis;
  } rsp_t;

  typedef struct {
    logic [1:0]  w;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] exp_rdata;
    logic        exp_write;
  } vec_t;

  rsp_t        q[$];
  logic [63:0] mm [1024];
  int          m_out;
  int          cyc;
  int          tests;
  int          fails;
  logic [63:0] exp_dbg;
  bit          dbg_known;
  bit          popped;
  logic [63:0] pop_rdata;
  logic        pop_write;
  vec_t        tbl [12];
  int          ntbl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Apply one accepted request to the model array and return its response.
  task automatic model_req(input logic [1:0] w, input logic [63:0] a, input logic [63:0] d,
                           output rsp_t r);
    int idx;
    bit mis;
    idx = int'(a[12:3]);
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (w == 2'b10 && a[1:0] != 2'b00) || ((w == 2'b11 || w == 2'b00) && a[2:0] != 3'b000);
`endif
    r.rdata = 64'd0;
    r.write = (w != 2'b00);
    r.err   = mis;
    r.vis   = cyc + LAT;
    if (!mis) begin
      case (w)
        2'b00: r.rdata = mm[idx];
        2'b01: mm[idx][8*a[2:0] +: 8] = d[7:0];
        2'b10: mm[idx][32*a[2] +: 32] = d[31:0];
        default: mm[idx] = d;
      endcase
    end
  endtask

  // Check the DUT outputs for this cycle, advance the model by one cycle, then move to the next edge.
  task automatic step();
    bit          rdy;
    bit          ev;
    bit          pop;
    bit          acc;
    rsp_t        r;
    logic [63:0] nd;
    rdy = (m_out < DEPTH);
    ev  = (q.size() > 0) && (q[0].vis <= cyc);
    chk("req_ready", req_ready, rdy);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_rdata", rsp_rdata, q[0].rdata);
      chk("rsp_write", rsp_write, q[0].write);
      chk("rsp_err", rsp_err, q[0].err);
    end
    if (dbg_known) chk("dbg_data", dbg_data, exp_dbg);
    pop    = ev && rsp_ready;
    popped = 1'b0;
    nd     = mm[dbg_addr];
    if (reset) begin
      q.delete();
      m_out   = 0;
      exp_dbg = 64'd0;
    end else begin
      acc = req_valid && rdy;
      if (pop) begin
        popped    = 1'b1;
        pop_rdata = rsp_rdata;
        pop_write = rsp_write;
        void'(q.pop_front());
      end
      if (acc) begin
        model_req(req_write, req_addr, req_wdata, r);
        q.push_back(r);
      end
      m_out   = m_out + int'(acc) - int'(pop);
      exp_dbg = nd;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add_vec(input logic [1:0] w, input logic [63:0] a, input logic [63:0] d,
                         input logic [63:0] e, input logic wr);
    tbl[ntbl].w         = w;
    tbl[ntbl].a         = a;
    tbl[ntbl].d         = d;
    tbl[ntbl].exp_rdata = e;
    tbl[ntbl].exp_write = wr;
    ntbl++;
  endtask

  task automatic issue(input logic [1:0] w, input logic [63:0] a, input logic [63:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  got;
    int  cnt;
    tests = 0; fails = 0; cyc = 0; m_out = 0; ntbl = 0;
    dbg_known = 1'b0; exp_dbg = 64'd0;
    pop_rdata = 64'd0; pop_write = 1'b0; popped = 1'b0;
    for (int i = 0; i < 1024; i++) mm[i] = 64'd0;
    reset = 1'b1; req_valid = 1'b0; req_write = 2'b00; req_addr = 64'd0; req_wdata = 64'd0;
    rsp_ready = 1'b1; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_dbg_data", dbg_data, 0);

    // Fill every dword with a known pattern so that every later read has a defined value.
    for (int i = 0; i < 1024; i++) begin
      issue(2'b11, 64'(i) << 3, {32'hA500_0000 ^ 32'(i), 32'(i) * 32'h9E37_79B9});
    end
    dbg_known = 1'b1;
    repeat (4) step();

    // Directed vectors, written as {op, addr, wdata, expected rdata, expected write}.
    add_vec(2'b11, 64'h10,   64'h0123_4567_89AB_CDEF, 64'd0,                   1'b1);
    add_vec(2'b00, 64'h10,   64'd0,                   64'h0123_4567_89AB_CDEF, 1'b0);
    add_vec(2'b01, 64'h13,   64'hAA,                  64'd0,                   1'b1);
    add_vec(2'b10, 64'h14,   64'hDEAD_BEEF,           64'd0,                   1'b1);
    add_vec(2'b00, 64'h10,   64'd0,                   64'hDEAD_BEEF_AAAB_CDEF, 1'b0);
    add_vec(2'b00, 64'h2010, 64'd0,                   64'hDEAD_BEEF_AAAB_CDEF, 1'b0);
`ifndef MEM_MISALIGN_TRAP_EN
    add_vec(2'b11, 64'h11,   64'h1122_3344_5566_7788, 64'd0,                   1'b1);
    add_vec(2'b00, 64'h10,   64'd0,                   64'h1122_3344_5566_7788, 1'b0);
    add_vec(2'b10, 64'h16,   64'hCAFE_F00D,           64'd0,                   1'b1);
    add_vec(2'b00, 64'h10,   64'd0,                   64'hCAFE_F00D_5566_7788, 1'b0);
    add_vec(2'b01, 64'h17,   64'hFFFF_FFFF_FFFF_FF00, 64'd0,                   1'b1);
    add_vec(2'b00, 64'h10,   64'd0,                   64'h00FE_F00D_5566_7788, 1'b0);
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < ntbl; i++) begin
      issue(tbl[i].w, tbl[i].a, tbl[i].d);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 10) begin
        step();
        lat++;
        if (popped) got = 1'b1;
      end
      chk("tbl_response_seen", got, 1);
      if (got) begin
        chk("tbl_rdata", pop_rdata, tbl[i].exp_rdata);
        chk("tbl_write", pop_write, tbl[i].exp_write);
        chk("tbl_latency", lat, LAT);
      end
    end

    // Debug port: the value at index 2 appears one cycle after dbg_addr is set.
    dbg_addr = 10'd2;
    step();
    chk("dbg_idx2", dbg_data, tbl[ntbl-1].exp_rdata);
    dbg_addr = 10'd0;

    // Backpressure: only DEPTH reads are accepted; ready returns one cycle after the first pop.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_write = 2'b00;
      req_addr  = 64'((i + 8) * 8);
      chk("bp_ready", req_ready, (i < DEPTH) ? 1 : 0);
      step();
    end
    req_valid = 1'b0;
    step();
    step();
    rsp_ready = 1'b1;
    chk("bp_ready_full", req_ready, 0);
    step();
    cnt = popped ? 1 : 0;
    chk("bp_ready_back", req_ready, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      if (popped) cnt++;
    end
    chk("bp_pops", cnt, DEPTH);

    // Reset with reads in flight: no stale responses, but committed writes survive.
    issue(2'b11, 64'h40, 64'hFEED_FACE_1234_5678);
    repeat (4) step();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(2'b00, 64'h40, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_stale", rsp_valid, 0);
      step();
    end
    issue(2'b00, 64'h40, 64'd0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (popped) got = 1'b1;
    end
    chk("rst_rd_seen", got, 1);
    if (got) chk("rst_write_kept", pop_rdata, 64'hFEED_FACE_1234_5678);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 399) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 2'($urandom_range(0, 3));
      req_addr  = {$urandom(), $urandom()};
      req_wdata = {$urandom(), $urandom()};
      rsp_ready = ($urandom_range(0, 9) < 7);
      dbg_addr  = 10'($urandom_range(0, 1023));
      step();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) step();
    chk("drain_empty", rsp_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
